// File: rtl/lisp_defs.sv
// lisp_defs: shared cell-memory types, constants and arbiter state/grant encodings
package lisp_defs;

    typedef logic [11:0] address_t;

    localparam logic [15:0] LISP_NIL    = 16'h0000;
    localparam logic [15:0] FETCH_ERROR = 16'hAAAA;
    localparam logic [15:0] STATE_ERROR = 16'h6666;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERROR = 3'd4
    } arb_state_t;

    typedef enum logic {
        EVAL  = 1'b0,
        ALLOC = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/cell_mem_arbiter.sv
// cell_mem_arbiter: round-robin arbiter sharing one cell memory between evaluator and allocator (optional CELL_ARB_BOUNDS_CHECK_EN)
module cell_mem_arbiter
    import lisp_defs::*;
#(
    parameter int       MEM_LATENCY = 1,
    parameter address_t ADDR_LIMIT  = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eval_req,
    input  address_t    eval_addr,
    output logic        eval_ack,
    output logic [15:0] eval_rdata,
    input  logic        alloc_req,
    input  logic        alloc_we,
    input  address_t    alloc_addr,
    input  logic [15:0] alloc_wdata,
    output logic        alloc_ack,
    output logic [15:0] alloc_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output address_t    mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        err,
    output logic [15:0] err_code
);

    arb_state_t  state_q, state_d;
    arb_grant_t  grant_q, grant_d, last_q, last_d, pick;
    address_t    addr_q, addr_d, pick_addr;
    logic        we_q, we_d, oob_q, oob_d, oob, err_q, err_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] wdata_q, wdata_d, eval_rdata_q, eval_rdata_d;
    logic [15:0] alloc_rdata_q, alloc_rdata_d, err_code_q, err_code_d;

    assign pick      = (eval_req && alloc_req) ? (last_q == EVAL ? ALLOC : EVAL) : (alloc_req ? ALLOC : EVAL);
    assign pick_addr = pick == ALLOC ? alloc_addr : eval_addr;

`ifdef CELL_ARB_BOUNDS_CHECK_EN
    assign oob = pick_addr > ADDR_LIMIT;
`else
    logic unused_limit;
    assign unused_limit = ^ADDR_LIMIT;
    assign oob          = 1'b0;
`endif

    // state and datapath registers; reset abandons any in-flight transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= EVAL;
            last_q        <= ALLOC;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            oob_q         <= 1'b0;
            cnt_q         <= '0;
            eval_rdata_q  <= '0;
            alloc_rdata_q <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            oob_q         <= oob_d;
            cnt_q         <= cnt_d;
            eval_rdata_q  <= eval_rdata_d;
            alloc_rdata_q <= alloc_rdata_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    // next state: grant in IDLE, one memory cycle in ISSUE, count latency in WAIT, ack in RESP
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        oob_d         = oob_q;
        cnt_d         = cnt_q;
        eval_rdata_d  = eval_rdata_q;
        alloc_rdata_d = alloc_rdata_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        case (state_q)
            IDLE: if (eval_req || alloc_req) begin
                state_d = ISSUE;
                grant_d = pick;
                last_d  = pick;
                addr_d  = pick_addr;
                we_d    = pick == ALLOC && alloc_we;
                wdata_d = pick == ALLOC ? alloc_wdata : 16'h0;
                oob_d   = oob;
            end
            ISSUE: if (oob_q) begin
                state_d       = RESP;
                err_d         = 1'b1;
                err_code_d    = FETCH_ERROR;
                eval_rdata_d  = grant_q == EVAL ? LISP_NIL : eval_rdata_q;
                alloc_rdata_d = grant_q == ALLOC ? LISP_NIL : alloc_rdata_q;
            end else begin
                state_d = we_q ? RESP : WAIT;
                cnt_d   = 2'(MEM_LATENCY - 1);
            end
            WAIT: if (cnt_q == 2'd0) begin
                state_d       = RESP;
                eval_rdata_d  = grant_q == EVAL ? mem_rdata : eval_rdata_q;
                alloc_rdata_d = grant_q == ALLOC ? mem_rdata : alloc_rdata_q;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
            RESP:  state_d = IDLE;
            ERROR: state_d = ERROR;
            default: begin
                state_d    = ERROR;
                err_d      = 1'b1;
                err_code_d = STATE_ERROR;
            end
        endcase
    end

    assign mem_en      = state_q == ISSUE && !oob_q;
    assign mem_we      = mem_en && we_q;
    assign mem_addr    = mem_en ? addr_q : '0;
    assign mem_wdata   = mem_en ? wdata_q : '0;
    assign eval_ack    = state_q == RESP && grant_q == EVAL;
    assign alloc_ack   = state_q == RESP && grant_q == ALLOC;
    assign eval_rdata  = eval_rdata_q;
    assign alloc_rdata = alloc_rdata_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// tb_cell_mem_arbiter: directed vectors for two arbiter instances (latency 1 and 3) with behavioural memories
module tb_cell_mem_arbiter;

    typedef struct {
        int          inst;
        logic        alloc;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] rd;
        int          lat;
        int          nmem;
        logic        err;
        logic [15:0] code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eval_req [2];
    logic [11:0] eval_addr [2];
    logic        eval_ack [2];
    logic [15:0] eval_rdata [2];
    logic        alloc_req [2];
    logic        alloc_we [2];
    logic [11:0] alloc_addr [2];
    logic [15:0] alloc_wdata [2];
    logic        alloc_ack [2];
    logic [15:0] alloc_rdata [2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [11:0] mem_addr [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic        err [2];
    logic [15:0] err_code [2];
    logic [15:0] mem [2][4096];
    logic [15:0] pipe [2][3];
    int          total = 0;
    int          bad = 0;
    vec_t        tbl [11];

    always #5 clk = ~clk;

    cell_mem_arbiter #(.MEM_LATENCY(1), .ADDR_LIMIT(12'h7FF)) u0 (
        .clk(clk), .rst(rst),
        .eval_req(eval_req[0]), .eval_addr(eval_addr[0]), .eval_ack(eval_ack[0]), .eval_rdata(eval_rdata[0]),
        .alloc_req(alloc_req[0]), .alloc_we(alloc_we[0]), .alloc_addr(alloc_addr[0]), .alloc_wdata(alloc_wdata[0]),
        .alloc_ack(alloc_ack[0]), .alloc_rdata(alloc_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .err(err[0]), .err_code(err_code[0])
    );

    cell_mem_arbiter #(.MEM_LATENCY(3), .ADDR_LIMIT(12'h7FF)) u1 (
        .clk(clk), .rst(rst),
        .eval_req(eval_req[1]), .eval_addr(eval_addr[1]), .eval_ack(eval_ack[1]), .eval_rdata(eval_rdata[1]),
        .alloc_req(alloc_req[1]), .alloc_we(alloc_we[1]), .alloc_addr(alloc_addr[1]), .alloc_wdata(alloc_wdata[1]),
        .alloc_ack(alloc_ack[1]), .alloc_rdata(alloc_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .err(err[1]), .err_code(err_code[1])
    );

    // read data appears exactly MEM_LATENCY cycles after the mem_en cycle, junk otherwise
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem[k][mem_addr[k]] : 16'hDEAD;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
            if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k]] = mem_wdata[k];
        end
    end

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, got, exp);
        end
    endtask

    function automatic logic all_zero(input int i);
        return !eval_ack[i] && !alloc_ack[i] && eval_rdata[i] == 16'h0 && alloc_rdata[i] == 16'h0 &&
               !mem_en[i] && !mem_we[i] && mem_addr[i] == 12'h0 && mem_wdata[i] == 16'h0 &&
               !err[i] && err_code[i] == 16'h0;
    endfunction

    task automatic run_txn(input string tag, input vec_t v);
        int          i = v.inst;
        int          lat = 0;
        int          nmem = 0;
        int          first = 0;
        logic        mok = 1'b1;
        logic [15:0] got = 16'h0;
        if (v.alloc) begin
            alloc_we[i] = v.we; alloc_addr[i] = v.addr; alloc_wdata[i] = v.wdata; alloc_req[i] = 1'b1;
        end else begin
            eval_addr[i] = v.addr; eval_req[i] = 1'b1;
        end
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (mem_en[i]) begin
                nmem++;
                if (first == 0) first = c;
                if (mem_we[i] != v.we || mem_addr[i] != v.addr || (v.we && mem_wdata[i] != v.wdata)) mok = 1'b0;
            end else if (mem_we[i] || mem_addr[i] != 12'h0 || mem_wdata[i] != 16'h0) mok = 1'b0;
            if (v.alloc ? alloc_ack[i] : eval_ack[i]) begin
                lat = c;
                got = v.alloc ? alloc_rdata[i] : eval_rdata[i];
            end
        end
        eval_req[i] = 1'b0;
        alloc_req[i] = 1'b0;
        chk({tag, "_lat"}, lat, v.lat);
        chk({tag, "_nmem"}, nmem, v.nmem);
        chk({tag, "_mem_first"}, first, v.nmem > 0 ? 1 : 0);
        chk({tag, "_mem_fields"}, mok, 1);
        if (v.chk) chk({tag, "_rdata"}, got, v.rd);
        @(posedge clk); #1;
        chk({tag, "_ack_one_cycle"}, {eval_ack[i], alloc_ack[i]}, 0);
        if (v.chk) chk({tag, "_rdata_hold"}, v.alloc ? alloc_rdata[i] : eval_rdata[i], v.rd);
        chk({tag, "_err"}, {err[i], err_code[i]}, {v.err, v.code});
    endtask

    initial begin
        int          ek [4];
        int          ec [4];
        logic [15:0] ed [4];
        int          nev = 0;
        int          ack_seen = 0;
        int          exp_k [4] = '{0, 1, 0, 1};
        int          exp_c [4] = '{3, 7, 11, 15};
        logic [15:0] exp_d [4] = '{16'h1234, 16'h4040, 16'h1234, 16'h4040};
        vec_t        v;
        for (int k = 0; k < 2; k++) begin
            eval_req[k] = 1'b0; eval_addr[k] = '0; alloc_req[k] = 1'b0;
            alloc_we[k] = 1'b0; alloc_addr[k] = '0; alloc_wdata[k] = '0;
            for (int a = 0; a < 4096; a++) mem[k][a] = 16'h0;
        end
        mem[0][12'h010] = 16'h1234;
        mem[0][12'h040] = 16'h4040;
        mem[0][12'h800] = 16'h8008;
        mem[1][12'h010] = 16'h5678;

        tbl[0]  = '{0, 1'b0, 1'b0, 12'h010, 16'h0,    1'b1, 16'h1234, 3, 1, 1'b0, 16'h0};
        tbl[1]  = '{0, 1'b1, 1'b1, 12'h020, 16'hBEEF, 1'b0, 16'h0,    2, 1, 1'b0, 16'h0};
        tbl[2]  = '{0, 1'b0, 1'b0, 12'h020, 16'h0,    1'b1, 16'hBEEF, 3, 1, 1'b0, 16'h0};
        tbl[3]  = '{0, 1'b1, 1'b0, 12'h040, 16'h0,    1'b1, 16'h4040, 3, 1, 1'b0, 16'h0};
        tbl[4]  = '{1, 1'b0, 1'b0, 12'h010, 16'h0,    1'b1, 16'h5678, 5, 1, 1'b0, 16'h0};
        tbl[5]  = '{1, 1'b1, 1'b1, 12'h030, 16'hCAFE, 1'b0, 16'h0,    2, 1, 1'b0, 16'h0};
        tbl[6]  = '{1, 1'b1, 1'b0, 12'h030, 16'h0,    1'b1, 16'hCAFE, 5, 1, 1'b0, 16'h0};
        tbl[7]  = '{0, 1'b1, 1'b1, 12'h7FF, 16'h0F0F, 1'b0, 16'h0,    2, 1, 1'b0, 16'h0};
        tbl[8]  = '{0, 1'b0, 1'b0, 12'h7FF, 16'h0,    1'b1, 16'h0F0F, 3, 1, 1'b0, 16'h0};
`ifdef CELL_ARB_BOUNDS_CHECK_EN
        tbl[9]  = '{0, 1'b0, 1'b0, 12'h800, 16'h0,    1'b1, 16'h0000, 2, 0, 1'b1, 16'hAAAA};
        tbl[10] = '{0, 1'b1, 1'b0, 12'h010, 16'h0,    1'b1, 16'h1234, 3, 1, 1'b1, 16'hAAAA};
`else
        tbl[9]  = '{0, 1'b0, 1'b0, 12'h800, 16'h0,    1'b1, 16'h8008, 3, 1, 1'b0, 16'h0};
        tbl[10] = '{0, 1'b1, 1'b0, 12'h010, 16'h0,    1'b1, 16'h1234, 3, 1, 1'b0, 16'h0};
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset_zero_u0", all_zero(0), 1);
        chk("reset_zero_u1", all_zero(1), 1);
        rst = 1'b0;

        // simultaneous requests held continuously: eval, alloc, eval, alloc
        eval_addr[0] = 12'h010;
        alloc_we[0] = 1'b0;
        alloc_addr[0] = 12'h040;
        eval_req[0] = 1'b1;
        alloc_req[0] = 1'b1;
        for (int c = 1; c <= 24 && nev < 4; c++) begin
            @(posedge clk); #1;
            if (eval_ack[0]) begin ek[nev] = 0; ec[nev] = c; ed[nev] = eval_rdata[0]; nev++; end
            if (alloc_ack[0] && nev < 4) begin ek[nev] = 1; ec[nev] = c; ed[nev] = alloc_rdata[0]; nev++; end
        end
        eval_req[0] = 1'b0;
        alloc_req[0] = 1'b0;
        chk("arb_events", nev, 4);
        for (int e = 0; e < nev; e++) begin
            chk($sformatf("arb%0d_who", e), ek[e], exp_k[e]);
            chk($sformatf("arb%0d_cycle", e), ec[e], exp_c[e]);
            chk($sformatf("arb%0d_rdata", e), ed[e], exp_d[e]);
        end
        @(posedge clk); #1;

        for (int t = 0; t < 11; t++) run_txn($sformatf("v%0d", t), tbl[t]);

        // reset in the middle of a latency-3 read
        eval_addr[1] = 12'h010;
        eval_req[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_zero_u1", all_zero(1), 1);
        chk("midrst_zero_u0", all_zero(0), 1);
        eval_req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (eval_ack[1] || alloc_ack[1] || mem_en[1]) ack_seen++;
        end
        chk("midrst_no_ack", ack_seen, 0);
        v = '{1, 1'b0, 1'b0, 12'h030, 16'h0, 1'b1, 16'hCAFE, 5, 1, 1'b0, 16'h0};
        run_txn("post_rst_u1", v);
        v = '{0, 1'b0, 1'b0, 12'h010, 16'h0, 1'b1, 16'h1234, 3, 1, 1'b0, 16'h0};
        run_txn("post_rst_u0", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
